// File: rtl/hpdcache_pkg.sv
// Shared types for the HPDcache refill path: MSHR slot ids, cache set/tag,
// requester ids and the refill controller state encoding.
package hpdcache_pkg;

  localparam int MSHR_SET_W     = 4;
  localparam int MSHR_WAY_W     = 2;
  localparam int HPDCACHE_SET_W = 7;
  localparam int HPDCACHE_TAG_W = 24;
  localparam int HPDCACHE_TID_W = 6;
  localparam int HPDCACHE_SID_W = 3;
  localparam int HPDCACHE_WRD_W = 3;

  typedef logic [MSHR_SET_W-1:0]     mshr_set_t;
  typedef logic [MSHR_WAY_W-1:0]     mshr_way_t;
  typedef logic [HPDCACHE_SET_W-1:0] hpdcache_set_t;
  typedef logic [HPDCACHE_TAG_W-1:0] hpdcache_tag_t;
  typedef logic [HPDCACHE_TID_W-1:0] hpdcache_req_tid_t;
  typedef logic [HPDCACHE_SID_W-1:0] hpdcache_req_sid_t;
  typedef logic [HPDCACHE_WRD_W-1:0] hpdcache_word_t;

  // Packed so that way lands in the MSBs, matching the {way,set} bus layout.
  typedef struct packed {
    mshr_way_t way;
    mshr_set_t set;
  } mshr_id_t;

  typedef struct packed {
    hpdcache_req_tid_t tid;
    hpdcache_req_sid_t sid;
    hpdcache_set_t     set;
    hpdcache_tag_t     tag;
    hpdcache_word_t    word;
    logic              need_rsp;
  } mshr_entry_t;

  typedef enum logic [2:0] {
    IDLE, ACK_REQ, ACK_RD, COLLECT, REFILL, RSP
  } refill_fsm_t;

endpackage

// File: rtl/hpdcache_refill_ctrl_if.sv
// Bundle of the refill controller's memory, MSHR-ack, cache-write and core
// response channels; slave = controller side, master = environment side.
interface hpdcache_refill_ctrl_if
  import hpdcache_pkg::*;
#(
  parameter int MEM_DATA_W = 64,
  parameter int LINE_W     = 512,
  parameter int WORD_W     = 64
) ();

  logic                  mem_rsp_valid_i;
  logic                  mem_rsp_ready_o;
  mshr_id_t              mem_rsp_id_i;
  logic [MEM_DATA_W-1:0] mem_rsp_data_i;
  logic                  mem_rsp_last_i;
  logic                  mem_rsp_error_i;

  logic                  ack_req_o;
  logic                  ack_gnt_i;
  mshr_set_t             ack_set_o;
  mshr_way_t             ack_way_o;
  hpdcache_req_tid_t     ack_req_id_i;
  hpdcache_req_sid_t     ack_src_id_i;
  hpdcache_set_t         ack_cache_set_i;
  hpdcache_tag_t         ack_cache_tag_i;
  hpdcache_word_t        ack_word_i;
  logic                  ack_need_rsp_i;
  logic                  ack_is_prefetch_i;

  logic                  refill_valid_o;
  logic                  refill_ready_i;
  hpdcache_set_t         refill_set_o;
  hpdcache_tag_t         refill_tag_o;
  logic [LINE_W-1:0]     refill_data_o;

  logic                  core_rsp_valid_o;
  logic                  core_rsp_ready_i;
  logic [WORD_W-1:0]     core_rsp_data_o;
  hpdcache_req_tid_t     core_rsp_tid_o;
  hpdcache_req_sid_t     core_rsp_sid_o;
  logic                  core_rsp_error_o;

  logic                  busy_o;

  modport slave (
    input  mem_rsp_valid_i, mem_rsp_id_i, mem_rsp_data_i, mem_rsp_last_i, mem_rsp_error_i,
    output mem_rsp_ready_o,
    output ack_req_o, ack_set_o, ack_way_o,
    input  ack_gnt_i, ack_req_id_i, ack_src_id_i, ack_cache_set_i, ack_cache_tag_i,
    input  ack_word_i, ack_need_rsp_i, ack_is_prefetch_i,
    output refill_valid_o, refill_set_o, refill_tag_o, refill_data_o,
    input  refill_ready_i,
    output core_rsp_valid_o, core_rsp_data_o, core_rsp_tid_o, core_rsp_sid_o, core_rsp_error_o,
    input  core_rsp_ready_i,
    output busy_o
  );

  modport master (
    output mem_rsp_valid_i, mem_rsp_id_i, mem_rsp_data_i, mem_rsp_last_i, mem_rsp_error_i,
    input  mem_rsp_ready_o,
    input  ack_req_o, ack_set_o, ack_way_o,
    output ack_gnt_i, ack_req_id_i, ack_src_id_i, ack_cache_set_i, ack_cache_tag_i,
    output ack_word_i, ack_need_rsp_i, ack_is_prefetch_i,
    input  refill_valid_o, refill_set_o, refill_tag_o, refill_data_o,
    output refill_ready_i,
    input  core_rsp_valid_o, core_rsp_data_o, core_rsp_tid_o, core_rsp_sid_o, core_rsp_error_o,
    output core_rsp_ready_i,
    input  busy_o
  );

endinterface

// File: rtl/hpdcache_refill_ctrl.sv
// Refill controller: releases the MSHR slot, gathers refill beats into a line, installs it
// and answers the core. First beat 3 cycles after valid; every channel is valid/ready-held.
module hpdcache_refill_ctrl
  import hpdcache_pkg::*;
#(
  parameter int MEM_DATA_W = 64,
  parameter int LINE_W     = 512,
  parameter int WORD_W     = 64
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  hpdcache_refill_ctrl_if.slave io
);

  localparam int BEATS = LINE_W / MEM_DATA_W;
  localparam int WORDS = LINE_W / WORD_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  refill_fsm_t                    state_q;
  mshr_id_t                       id_q;
  mshr_entry_t                    entry_q;
  logic [CNT_W-1:0]               beat_cnt_q;
  logic                           err_q;
  logic                           ack_req_q;
  logic                           mem_rdy_q;
  logic                           refill_vld_q;
  logic                           core_vld_q;
  logic [BEATS-1:0][MEM_DATA_W-1:0] line_q;
  logic [WORDS-1:0][WORD_W-1:0]   line_words;

  logic beat_hs;
  logic beat_at_end;
  logic beat_term;
  logic err_d;
  logic unused_prefetch;

  // mem_rdy_q is only ever high in COLLECT, so it doubles as the state qualifier.
  assign beat_hs     = io.mem_rsp_valid_i & mem_rdy_q;
  assign beat_at_end = (beat_cnt_q == LAST_BEAT);
  assign beat_term   = io.mem_rsp_last_i | beat_at_end;
  assign err_d       = err_q | io.mem_rsp_error_i | (io.mem_rsp_last_i != beat_at_end);

  assign unused_prefetch = io.ack_is_prefetch_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      id_q         <= '0;
      entry_q      <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
      ack_req_q    <= 1'b0;
      mem_rdy_q    <= 1'b0;
      refill_vld_q <= 1'b0;
      core_vld_q   <= 1'b0;
      line_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (io.mem_rsp_valid_i) begin
          id_q       <= io.mem_rsp_id_i;
          beat_cnt_q <= '0;
          err_q      <= 1'b0;
          ack_req_q  <= 1'b1;
          state_q    <= ACK_REQ;
        end
        ACK_REQ: if (io.ack_gnt_i) begin
          ack_req_q <= 1'b0;
          state_q   <= ACK_RD;
        end
        ACK_RD: begin
          entry_q   <= '{tid: io.ack_req_id_i, sid: io.ack_src_id_i,
                         set: io.ack_cache_set_i, tag: io.ack_cache_tag_i,
                         word: io.ack_word_i, need_rsp: io.ack_need_rsp_i};
          mem_rdy_q <= 1'b1;
          state_q   <= COLLECT;
        end
        COLLECT: if (beat_hs) begin
          line_q[beat_cnt_q] <= io.mem_rsp_data_i;
          err_q              <= err_d;
          if (beat_term) begin
            beat_cnt_q <= '0;
            mem_rdy_q  <= 1'b0;
            // A faulty line is never installed; the requester still gets an error reply.
            if (!err_d) begin
              refill_vld_q <= 1'b1;
              state_q      <= REFILL;
            end else if (entry_q.need_rsp) begin
              core_vld_q <= 1'b1;
              state_q    <= RSP;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
        end
        REFILL: if (io.refill_ready_i) begin
          refill_vld_q <= 1'b0;
          if (entry_q.need_rsp) begin
            core_vld_q <= 1'b1;
            state_q    <= RSP;
          end else begin
            state_q <= IDLE;
          end
        end
        RSP: if (io.core_rsp_ready_i) begin
          core_vld_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign line_words = line_q;

  assign io.mem_rsp_ready_o  = mem_rdy_q;
  assign io.ack_req_o        = ack_req_q;
  assign io.ack_set_o        = id_q.set;
  assign io.ack_way_o        = id_q.way;
  assign io.refill_valid_o   = refill_vld_q;
  assign io.refill_set_o     = entry_q.set;
  assign io.refill_tag_o     = entry_q.tag;
  assign io.refill_data_o    = line_q;
  assign io.core_rsp_valid_o = core_vld_q;
  assign io.core_rsp_data_o  = line_words[entry_q.word];
  assign io.core_rsp_tid_o   = entry_q.tid;
  assign io.core_rsp_sid_o   = entry_q.sid;
  assign io.core_rsp_error_o = err_q;
  assign io.busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_hpdcache_refill_ctrl.sv
// Bench for hpdcache_refill_ctrl: directed vector table, reset-in-flight sequence,
// then randomized refills scored against a line/response model.
module tb_hpdcache_refill_ctrl;
  import hpdcache_pkg::*;

  localparam int MEM_DATA_W = 64;
  localparam int LINE_W     = 512;
  localparam int WORD_W     = 64;
  localparam int BEATS      = LINE_W / MEM_DATA_W;

  logic clk_i;
  logic rst_ni;
  int   checks   = 0;
  int   failures = 0;
  logic [MEM_DATA_W-1:0] mline [BEATS];

  hpdcache_refill_ctrl_if #(.MEM_DATA_W(MEM_DATA_W), .LINE_W(LINE_W), .WORD_W(WORD_W)) bus ();

  hpdcache_refill_ctrl #(.MEM_DATA_W(MEM_DATA_W), .LINE_W(LINE_W), .WORD_W(WORD_W)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .io    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // last_at: beat index carrying last (>= BEATS means never); err_beat >= BEATS means none.
  typedef struct {
    int unsigned way, set, gnt_dly, need_rsp, is_pf, word;
    int unsigned last_at, err_beat, rdy_dly, rsp_dly, gaps;
    bit x_ref, x_rsp, x_err;
  } vec_t;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] model_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < BEATS; i++) l[i*MEM_DATA_W +: MEM_DATA_W] = mline[i];
    return l;
  endfunction

  task automatic noise_entry();
    bus.ack_req_id_i      = hpdcache_req_tid_t'($urandom);
    bus.ack_src_id_i      = hpdcache_req_sid_t'($urandom);
    bus.ack_cache_set_i   = hpdcache_set_t'($urandom);
    bus.ack_cache_tag_i   = hpdcache_tag_t'($urandom);
    bus.ack_word_i        = hpdcache_word_t'($urandom);
    bus.ack_need_rsp_i    = 1'($urandom);
    bus.ack_is_prefetch_i = 1'($urandom);
  endtask

  task automatic check_zero();
    chk("rst_ack_req", bus.ack_req_o, 0);
    chk("rst_ack_set", bus.ack_set_o, 0);
    chk("rst_ack_way", bus.ack_way_o, 0);
    chk("rst_mem_rdy", bus.mem_rsp_ready_o, 0);
    chk("rst_refill_vld", bus.refill_valid_o, 0);
    chk("rst_refill_set", bus.refill_set_o, 0);
    chk("rst_refill_tag", bus.refill_tag_o, 0);
    chk("rst_refill_data", bus.refill_data_o, 0);
    chk("rst_core_vld", bus.core_rsp_valid_o, 0);
    chk("rst_core_data", bus.core_rsp_data_o, 0);
    chk("rst_core_tid", bus.core_rsp_tid_o, 0);
    chk("rst_core_sid", bus.core_rsp_sid_o, 0);
    chk("rst_core_err", bus.core_rsp_error_o, 0);
    chk("rst_busy", bus.busy_o, 0);
  endtask

  task automatic run_tx(input vec_t v, input bit x_ref, input bit x_rsp, input bit x_err);
    logic [MEM_DATA_W-1:0] beat [BEATS];
    hpdcache_req_tid_t tid;
    hpdcache_req_sid_t sid;
    hpdcache_set_t     cset;
    hpdcache_tag_t     ctag;
    int                nb;
    tid  = hpdcache_req_tid_t'($urandom);
    sid  = hpdcache_req_sid_t'($urandom);
    cset = hpdcache_set_t'($urandom);
    ctag = hpdcache_tag_t'($urandom);
    for (int i = 0; i < BEATS; i++) beat[i] = {$urandom, $urandom};
    nb = (v.last_at >= BEATS - 1) ? BEATS : int'(v.last_at) + 1;

    bus.mem_rsp_id_i    = '{way: mshr_way_t'(v.way), set: mshr_set_t'(v.set)};
    bus.mem_rsp_data_i  = beat[0];
    bus.mem_rsp_last_i  = (v.last_at == 0);
    bus.mem_rsp_error_i = (v.err_beat == 0);
    bus.mem_rsp_valid_i = 1'b1;
    step();
    chk("ack_req_rise", bus.ack_req_o, 1);
    chk("ack_set", bus.ack_set_o, v.set);
    chk("ack_way", bus.ack_way_o, v.way);
    chk("busy_on", bus.busy_o, 1);
    bus.mem_rsp_id_i = mshr_id_t'($urandom);
    bus.ack_gnt_i    = 1'b0;
    for (int k = 0; k < int'(v.gnt_dly); k++) begin
      step();
      chk("ack_req_hold", bus.ack_req_o, 1);
      chk("rdy_while_ack", bus.mem_rsp_ready_o, 0);
    end
    bus.ack_gnt_i = 1'b1;
    step();
    bus.ack_gnt_i = 1'($urandom);
    chk("ack_req_fall", bus.ack_req_o, 0);
    chk("rdy_ack_rd", bus.mem_rsp_ready_o, 0);
    bus.ack_req_id_i      = tid;
    bus.ack_src_id_i      = sid;
    bus.ack_cache_set_i   = cset;
    bus.ack_cache_tag_i   = ctag;
    bus.ack_word_i        = hpdcache_word_t'(v.word);
    bus.ack_need_rsp_i    = v.need_rsp[0];
    bus.ack_is_prefetch_i = v.is_pf[0];
    step();
    noise_entry();
    chk("rdy_rise", bus.mem_rsp_ready_o, 1);

    for (int i = 0; i < nb; i++) begin
      if (i > 0) begin
        if (v.gaps != 0) begin
          bus.mem_rsp_valid_i = 1'b0;
          for (int g = $urandom_range(0, 2); g > 0; g--) begin
            step();
            chk("rdy_gap", bus.mem_rsp_ready_o, 1);
          end
        end
        bus.mem_rsp_id_i    = mshr_id_t'($urandom);
        bus.mem_rsp_data_i  = beat[i];
        bus.mem_rsp_last_i  = (v.last_at == i);
        bus.mem_rsp_error_i = (v.err_beat == i);
        bus.mem_rsp_valid_i = 1'b1;
      end
      chk("rdy_beat", bus.mem_rsp_ready_o, 1);
      mline[i] = beat[i];
      bus.ack_gnt_i        = 1'($urandom);
      bus.refill_ready_i   = 1'($urandom);
      bus.core_rsp_ready_i = 1'($urandom);
      step();
    end
    bus.mem_rsp_valid_i  = 1'b0;
    bus.ack_gnt_i        = 1'b0;
    bus.refill_ready_i   = 1'b0;
    bus.core_rsp_ready_i = 1'b0;
    chk("rdy_end", bus.mem_rsp_ready_o, 0);
    chk("refill_vld", bus.refill_valid_o, x_ref);

    if (x_ref) begin
      for (int k = 0; k < int'(v.rdy_dly); k++) begin
        chk("refill_hold_vld", bus.refill_valid_o, 1);
        chk("refill_hold_data", bus.refill_data_o, model_line());
        bus.core_rsp_ready_i = 1'($urandom);
        bus.ack_gnt_i        = 1'($urandom);
        step();
      end
      chk("refill_data", bus.refill_data_o, model_line());
      chk("refill_set", bus.refill_set_o, cset);
      chk("refill_tag", bus.refill_tag_o, ctag);
      bus.refill_ready_i = 1'b1;
      step();
      bus.refill_ready_i   = 1'b0;
      bus.core_rsp_ready_i = 1'b0;
      chk("refill_done", bus.refill_valid_o, 0);
    end

    chk("core_vld", bus.core_rsp_valid_o, x_rsp);
    if (x_rsp) begin
      for (int k = 0; k < int'(v.rsp_dly); k++) begin
        chk("core_hold_vld", bus.core_rsp_valid_o, 1);
        chk("core_hold_data", bus.core_rsp_data_o, mline[v.word]);
        bus.refill_ready_i = 1'($urandom);
        bus.ack_gnt_i      = 1'($urandom);
        step();
      end
      chk("core_data", bus.core_rsp_data_o, mline[v.word]);
      chk("core_err", bus.core_rsp_error_o, x_err);
      chk("core_tid", bus.core_rsp_tid_o, tid);
      chk("core_sid", bus.core_rsp_sid_o, sid);
      bus.core_rsp_ready_i = 1'b1;
      step();
      bus.core_rsp_ready_i = 1'b0;
      bus.refill_ready_i   = 1'b0;
      chk("core_done", bus.core_rsp_valid_o, 0);
    end
    chk("idle_busy", bus.busy_o, 0);
    chk("idle_refill_vld", bus.refill_valid_o, 0);
  endtask

  vec_t tbl [9];
  vec_t rv;
  bit   r_err;
  int   r_nb;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // way,set,gnt,need,pf,word,last,err,rdy,rsp,gaps, ref,rsp,err
    tbl[0] = '{1, 3, 0, 1, 0, 5, 7, 8, 0, 0, 0, 1, 1, 0};  // nominal
    tbl[1] = '{2, 9, 0, 0, 1, 2, 7, 8, 0, 0, 0, 1, 0, 0};  // prefetch
    tbl[2] = '{0, 15, 4, 1, 0, 0, 7, 8, 0, 1, 0, 1, 1, 0}; // grant stall
    tbl[3] = '{3, 6, 0, 1, 0, 2, 7, 2, 0, 0, 0, 0, 1, 1};  // bus error beat 2
    tbl[4] = '{1, 1, 1, 1, 0, 5, 3, 8, 0, 0, 0, 0, 1, 1};  // early last, stale word
    tbl[5] = '{2, 4, 0, 1, 0, 7, 7, 8, 3, 2, 0, 1, 1, 0};  // refill backpressure
    tbl[6] = '{0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 1};  // error, no response
    tbl[7] = '{3, 12, 2, 1, 0, 7, 8, 8, 0, 0, 1, 0, 1, 1}; // last never asserted
    tbl[8] = '{1, 2, 0, 1, 0, 0, 0, 8, 0, 0, 0, 0, 1, 1};  // last on beat 0

    rst_ni               = 1'b0;
    bus.mem_rsp_valid_i  = 1'b0;
    bus.mem_rsp_id_i     = '0;
    bus.mem_rsp_data_i   = '0;
    bus.mem_rsp_last_i   = 1'b0;
    bus.mem_rsp_error_i  = 1'b0;
    bus.ack_gnt_i        = 1'b0;
    bus.refill_ready_i   = 1'b0;
    bus.core_rsp_ready_i = 1'b0;
    noise_entry();
    for (int i = 0; i < BEATS; i++) mline[i] = '0;
    step();
    step();
    check_zero();
    rst_ni = 1'b1;
    step();

    for (int t = 0; t < 9; t++) run_tx(tbl[t], tbl[t].x_ref, tbl[t].x_rsp, tbl[t].x_err);

    // Reset while collecting beats drops the refill and the line buffer.
    bus.mem_rsp_id_i    = '{way: 2'd2, set: 4'd5};
    bus.mem_rsp_data_i  = {$urandom, $urandom};
    bus.mem_rsp_last_i  = 1'b0;
    bus.mem_rsp_error_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b1;
    step();
    bus.ack_gnt_i = 1'b1;
    step();
    bus.ack_gnt_i = 1'b0;
    step();
    chk("rstc_rdy", bus.mem_rsp_ready_o, 1);
    step();
    rst_ni              = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    step();
    check_zero();
    rst_ni = 1'b1;
    for (int i = 0; i < BEATS; i++) mline[i] = '0;
    step();
    run_tx(tbl[0], 1'b1, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rv.way      = $urandom_range(0, 3);
      rv.set      = $urandom_range(0, 15);
      rv.gnt_dly  = $urandom_range(0, 3);
      rv.is_pf    = ($urandom_range(0, 3) == 0);
      rv.need_rsp = rv.is_pf ? 0 : $urandom_range(0, 1);
      rv.word     = $urandom_range(0, 7);
      rv.last_at  = ($urandom_range(0, 9) < 7) ? 7 : $urandom_range(0, 8);
      rv.err_beat = ($urandom_range(0, 3) != 0) ? 8 : $urandom_range(0, 7);
      rv.rdy_dly  = $urandom_range(0, 2);
      rv.rsp_dly  = $urandom_range(0, 2);
      rv.gaps     = $urandom_range(0, 1);
      r_nb  = (rv.last_at >= BEATS - 1) ? BEATS : int'(rv.last_at) + 1;
      r_err = (rv.last_at != BEATS - 1) || (int'(rv.err_beat) < r_nb);
      run_tx(rv, !r_err, rv.need_rsp != 0, r_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
